// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer
//   Ethernet transmit framer in the tx_clk domain. Takes a byte stream with a
//   valid/ready/last handshake and drives a registered GMII transmit bus. Each
//   frame gets a preamble and SFD in front. Short payloads are zero-padded to
//   MIN_PAYLOAD. A CRC-32 FCS is appended, LSB byte first. An inter-frame gap of
//   IFG_BYTES idle cycles follows every frame or abort.
//
// Ports
//   tx_clk      transmit byte clock
//   rst_n       asynchronous active-low reset
//   s_data      payload byte
//   s_valid     s_data valid
//   s_last      s_data is the final payload byte of the frame
//   s_err       send this byte with tx_er=1
//   s_ready     byte accepted this cycle when s_valid & s_ready
//   tx_data     GMII TXD (registered)
//   tx_en       GMII TX_EN (registered)
//   tx_er       GMII TX_ER (registered)
//   busy        framer is not idle
//   frame_done  pulse alongside the last FCS byte
//   underrun    pulse alongside the abort byte when the source stalls mid-payload
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic       tx_clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    input  logic       s_err,
    output logic       s_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_PAYLOAD,
        S_PAD,
        S_FCS,
        S_ABORT,
        S_DRAIN,
        S_IFG
    } state_t;

    // The state names the byte that is currently on tx_data. The transition
    // logic therefore computes the next bus byte together with the next state.
    state_t      state_q, state_d;
    logic [15:0] step_q, step_d;     // preamble, FCS and IFG position
    logic [15:0] count_q, count_d;   // payload+pad bytes sent, saturating
    logic [31:0] crc_q, crc_d;
    logic        last_q, last_d;     // byte on the bus was the frame's s_last byte
    logic [7:0]  data_d;
    logic        en_d, er_d, done_d, und_d;
    logic [31:0] fcs;
    logic [15:0] count_inc;

    // Reflected CRC-32 (poly 0xEDB88320), one byte per call, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign fcs       = ~crc_q;
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    assign busy      = (state_q != S_IDLE);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        count_d = count_q;
        crc_d   = crc_q;
        last_d  = last_q;
        data_d  = 8'h00;
        en_d    = 1'b0;
        er_d    = 1'b0;
        done_d  = 1'b0;
        und_d   = 1'b0;
        s_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The pending byte is only observed here. It is consumed later,
                // while the SFD is on the bus.
                if (s_valid) begin
                    state_d = S_PRE;
                    step_d  = '0;
                    count_d = '0;
                    crc_d   = 32'hFFFF_FFFF;
                    last_d  = 1'b0;
                    data_d  = 8'h55;
                    en_d    = 1'b1;
                end
            end

            S_PRE: begin
                en_d = 1'b1;
                if (step_q == 16'(PREAMBLE_LEN - 1)) begin
                    state_d = S_SFD;
                    data_d  = 8'hD5;
                end else begin
                    step_d = step_q + 16'd1;
                    data_d = 8'h55;
                end
            end

            // SFD shares the payload logic. last_q is always clear in SFD, so the
            // first payload byte is taken in the SFD cycle and the payload
            // follows the SFD without a gap.
            S_SFD, S_PAYLOAD, S_PAD: begin
                en_d = 1'b1;
                if (state_q != S_PAD && !last_q) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        state_d = S_PAYLOAD;
                        data_d  = s_data;
                        er_d    = s_err;
                        crc_d   = crc_byte(crc_q, s_data);
                        count_d = count_inc;
                        last_d  = s_last;
                    end else begin
                        // The source stalled before s_last, so the frame is
                        // poisoned and dropped.
                        state_d = S_ABORT;
                        er_d    = 1'b1;
                        und_d   = 1'b1;
                    end
                end else if (count_q < 16'(MIN_PAYLOAD)) begin
                    state_d = S_PAD;
                    crc_d   = crc_byte(crc_q, 8'h00);
                    count_d = count_inc;
                end else begin
                    state_d = S_FCS;
                    step_d  = '0;
                    data_d  = fcs[7:0];
                end
            end

            S_FCS: begin
                en_d = 1'b1;
                // crc_q is frozen here, so fcs holds all four FCS bytes.
                case (step_q[1:0])
                    2'd0:    data_d = fcs[15:8];
                    2'd1:    data_d = fcs[23:16];
                    2'd2: begin
                        data_d = fcs[31:24];
                        done_d = 1'b1;
                    end
                    default: begin
                        en_d    = 1'b0;
                        state_d = S_IFG;
                    end
                endcase
                step_d = (step_q[1:0] == 2'd3) ? 16'd0 : step_q + 16'd1;
            end

            S_ABORT: state_d = S_DRAIN;

            S_DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_d = S_IFG;
                    step_d  = '0;
                end
            end

            S_IFG: begin
                if (step_q == 16'(IFG_BYTES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    step_d = step_q + 16'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together at the edge, whatever order the statements are in.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            count_q    <= '0;
            crc_q      <= 32'hFFFF_FFFF;
            last_q     <= 1'b0;
            tx_data    <= 8'h00;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            count_q    <= count_d;
            crc_q      <= crc_d;
            last_q     <= last_d;
            tx_data    <= data_d;
            tx_en      <= en_d;
            tx_er      <= er_d;
            frame_done <= done_d;
            underrun   <= und_d;
        end
    end

endmodule
